// File: rtl/adc_capture_pkg.sv
// Shared IAGC status codes, capture FSM state type and accumulator sizing
// for the ADC sample capture block.
package adc_capture_pkg;

  localparam logic [3:0] IAGC_RESET  = 4'b0000;
  localparam logic [3:0] IAGC_SAMPLE = 4'b0011;
  localparam logic [3:0] IAGC_HALT   = 4'b1100;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_IDLE      = 2'd1,
    ST_CAPTURE   = 2'd2
  } state_e;

  // Headroom for summing up to 2^max_dec_log2 signed samples.
  function automatic int acc_width(input int in_width, input int max_dec_log2);
    return in_width + max_dec_log2;
  endfunction

endpackage

// File: rtl/adc_channel_reducer.sv
// One channel's window reduction: holds the first sample of the window (default)
// or accumulates and averages it when ADC_CAPTURE_AVG_EN is defined, then MSB-truncates.
module adc_channel_reducer
  import adc_capture_pkg::*;
#(
  parameter int IN_WIDTH     = 16,
  parameter int OUT_WIDTH    = 14
`ifdef ADC_CAPTURE_AVG_EN
  ,
  parameter int MAX_DEC_LOG2 = 7,
  parameter int KW           = 3
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 strobe_i,
`ifdef ADC_CAPTURE_AVG_EN
  input  logic                 clr_i,
  input  logic                 last_i,
  input  logic [KW-1:0]        k_i,
`else
  input  logic                 first_i,
`endif
  input  logic [IN_WIDTH-1:0]  sample_i,
  output logic [OUT_WIDTH-1:0] result_o
);

  logic [IN_WIDTH-1:0] pick;

`ifdef ADC_CAPTURE_AVG_EN
  localparam int AW = acc_width(IN_WIDTH, MAX_DEC_LOG2);

  logic signed [AW-1:0] acc_q, acc_d, sum, avg;

  // sum includes the current strobe so the closing sample is averaged in.
  assign sum  = acc_q + {{MAX_DEC_LOG2{sample_i[IN_WIDTH-1]}}, sample_i};
  assign avg  = sum >>> k_i;
  assign pick = avg[IN_WIDTH-1:0];

  always_comb begin
    acc_d = acc_q;
    if (clr_i)         acc_d = '0;
    else if (strobe_i) acc_d = last_i ? '0 : sum;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end
`else
  logic [IN_WIDTH-1:0] held_q, held_d;

  // For a one-sample window the result must bypass the hold register.
  assign pick = first_i ? sample_i : held_q;

  always_comb begin
    held_d = held_q;
    if (strobe_i && first_i) held_d = sample_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) held_q <= '0;
    else       held_q <= held_d;
  end
`endif

  assign result_o = pick[IN_WIDTH-1 -: OUT_WIDTH];

endmodule

// File: rtl/adc_sample_capture.sv
// ADC sample capture: IAGC-gated 2^k window decimation onto a valid/ready output.
// Build option ADC_CAPTURE_AVG_EN selects window averaging instead of first-sample hold.
//
// state        | meaning
// ST_WAIT_INIT | controller not initialised; strobes ignored
// ST_IDLE      | initialised, waiting for IAGC SAMPLE status
// ST_CAPTURE   | counting strobes into windows and emitting results
module adc_sample_capture
  import adc_capture_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int IN_WIDTH         = 16,
  parameter int OUT_WIDTH        = 14,
  parameter int MAX_DEC_LOG2     = 7,
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                                i_sys_clock,
  input  logic                                i_reset,
  input  logic [IAGC_STATUS_SIZE-1:0]         i_iagc_status,
  input  logic                                i_init_done,
  input  logic                                i_sample_valid,
  input  logic [NUM_CH*IN_WIDTH-1:0]          i_samples,
  input  logic [$clog2(MAX_DEC_LOG2+1)-1:0]   i_dec_log2,
  output logic [NUM_CH*OUT_WIDTH-1:0]         o_data,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic                                o_overrun,
  output logic [CNT_WIDTH-1:0]                o_sample_count,
  output logic                                o_busy
);

  localparam int KW = $clog2(MAX_DEC_LOG2 + 1);
  localparam int WW = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

  state_e                      state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic [WW-1:0]               win_q, win_d;
  logic [WW:0]                 win_term;
  logic [NUM_CH*OUT_WIDTH-1:0] data_q, data_d, result;
  logic                        valid_q, valid_d, ovr_q, ovr_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        is_sample, enter_cap, strobe_cap;
  logic                        win_first, win_last, win_close, accept;

  assign is_sample = (i_iagc_status == IAGC_STATUS_SIZE'(IAGC_SAMPLE));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT_INIT: if (i_init_done) state_d = ST_IDLE;
      ST_IDLE:      if (is_sample)   state_d = ST_CAPTURE;
      ST_CAPTURE:   if (!is_sample)  state_d = ST_IDLE;
      default:                       state_d = ST_WAIT_INIT;
    endcase
    if (!i_init_done) state_d = ST_WAIT_INIT;
  end

  assign enter_cap  = (state_q != ST_CAPTURE) && (state_d == ST_CAPTURE);
  assign strobe_cap = (state_q == ST_CAPTURE) && i_sample_valid;
  assign win_term   = ((WW+1)'(1) << k_q) - (WW+1)'(1);
  assign win_first  = (win_q == '0);
  assign win_last   = ({1'b0, win_q} == win_term);
  assign win_close  = strobe_cap && win_last;
  assign accept     = valid_q && i_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    adc_channel_reducer #(
      .IN_WIDTH     (IN_WIDTH),
      .OUT_WIDTH    (OUT_WIDTH)
`ifdef ADC_CAPTURE_AVG_EN
      ,
      .MAX_DEC_LOG2 (MAX_DEC_LOG2),
      .KW           (KW)
`endif
    ) u_reducer (
      .clk_i    (i_sys_clock),
      .rst_i    (i_reset),
      .strobe_i (strobe_cap),
`ifdef ADC_CAPTURE_AVG_EN
      .clr_i    (enter_cap),
      .last_i   (win_last),
      .k_i      (k_q),
`else
      .first_i  (win_first),
`endif
      .sample_i (i_samples[c*IN_WIDTH +: IN_WIDTH]),
      .result_o (result[c*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  always_comb begin
    k_d     = k_q;
    win_d   = win_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    if (enter_cap) begin
      k_d   = (i_dec_log2 > KW'(MAX_DEC_LOG2)) ? KW'(MAX_DEC_LOG2) : i_dec_log2;
      win_d = '0;
      ovr_d = 1'b0;
    end else if (strobe_cap) begin
      win_d = win_last ? '0 : win_q + WW'(1);
    end
    if (accept) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CNT_WIDTH'(1);
    end
    // A result that finds the output still occupied is dropped, not queued.
    if (win_close) begin
      if (!valid_q || i_ready) begin
        data_d  = result;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_sys_clock) begin
    if (i_reset) begin
      state_q <= ST_WAIT_INIT;
      k_q     <= '0;
      win_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      win_q   <= win_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_data         = data_q;
  assign o_valid        = valid_q;
  assign o_overrun      = ovr_q;
  assign o_sample_count = cnt_q;
  assign o_busy         = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_adc_sample_capture.sv
// Scoreboard bench for adc_sample_capture: a window-level reference model queues
// expected results; a negedge monitor checks each accepted output.
module tb_adc_sample_capture;

  localparam int NUM_CH = 2, IN_WIDTH = 16, OUT_WIDTH = 14, MAX_DEC_LOG2 = 7;
  localparam int ISZ = 4, CNT_WIDTH = 32;
  localparam int KW = $clog2(MAX_DEC_LOG2 + 1);
  localparam logic [3:0] SAMPLE = 4'b0011;
  localparam logic [3:0] IDLE_ST = 4'b0001;

  logic                        clk = 1'b0;
  logic                        i_reset = 1'b0;
  logic [ISZ-1:0]              i_iagc_status = '0;
  logic                        i_init_done = 1'b0;
  logic                        i_sample_valid = 1'b0;
  logic [NUM_CH*IN_WIDTH-1:0]  i_samples = '0;
  logic [KW-1:0]               i_dec_log2 = '0;
  logic                        i_ready = 1'b0;
  logic [NUM_CH*OUT_WIDTH-1:0] o_data;
  logic                        o_valid, o_overrun, o_busy;
  logic [CNT_WIDTH-1:0]        o_sample_count;

  always #5 clk = ~clk;

  adc_sample_capture #(
    .NUM_CH(NUM_CH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .MAX_DEC_LOG2(MAX_DEC_LOG2), .IAGC_STATUS_SIZE(ISZ), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .i_sys_clock(clk), .i_reset(i_reset), .i_iagc_status(i_iagc_status),
    .i_init_done(i_init_done), .i_sample_valid(i_sample_valid), .i_samples(i_samples),
    .i_dec_log2(i_dec_log2), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_overrun(o_overrun), .o_sample_count(o_sample_count), .o_busy(o_busy)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec-level view (mode, latched k, window sample list, output slot).
  logic [NUM_CH*OUT_WIDTH-1:0] exp_q[$];
  logic [NUM_CH*IN_WIDTH-1:0]  m_win[$];
  int m_mode = 0;   // 0 uninitialised, 1 idle, 2 capturing
  int m_k = 0;
  bit m_slot = 0, m_ovr = 0;
  int m_cnt = 0;

  function automatic logic [NUM_CH*OUT_WIDTH-1:0] ref_result(input int k);
    logic [NUM_CH*OUT_WIDTH-1:0] r;
    longint v;
    logic [IN_WIDTH-1:0] a;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef ADC_CAPTURE_AVG_EN
      v = 0;
      foreach (m_win[i]) v += longint'($signed(m_win[i][c*IN_WIDTH +: IN_WIDTH]));
      v = v >>> k;
`else
      v = longint'($signed(m_win[0][c*IN_WIDTH +: IN_WIDTH]));
`endif
      a = v[IN_WIDTH-1:0];
      r[c*OUT_WIDTH +: OUT_WIDTH] = a[IN_WIDTH-1 -: OUT_WIDTH];
    end
    return r;
  endfunction

  task automatic model_edge();
    if (i_reset) begin
      m_mode = 0; m_win.delete(); m_slot = 0; m_ovr = 0; m_cnt = 0; exp_q.delete();
      return;
    end
    if (m_slot && i_ready) begin
      m_slot = 0;
      m_cnt++;
    end
    if (m_mode == 2 && i_sample_valid) begin
      m_win.push_back(i_samples);
      if (m_win.size() == (1 << m_k)) begin
        if (m_slot) m_ovr = 1;
        else begin
          exp_q.push_back(ref_result(m_k));
          m_slot = 1;
        end
        m_win.delete();
      end
    end
    if (!i_init_done) begin
      m_mode = 0; m_win.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && i_iagc_status == SAMPLE) begin
      m_mode = 2;
      m_k = (int'(i_dec_log2) > MAX_DEC_LOG2) ? MAX_DEC_LOG2 : int'(i_dec_log2);
      m_win.delete();
      m_ovr = 0;
    end else if (m_mode == 2 && i_iagc_status != SAMPLE) begin
      m_mode = 1; m_win.delete();
    end
  endtask

  task automatic cycle(input bit sv, input logic [NUM_CH*IN_WIDTH-1:0] smp, input bit rdy);
    i_sample_valid = sv;
    i_samples      = smp;
    i_ready        = rdy;
    model_edge();
    @(posedge clk);
    #1;
    chk("valid", o_valid, m_slot);
    chk("busy", o_busy, (m_mode == 2));
    chk("overrun", o_overrun, m_ovr);
    i_sample_valid = 1'b0;
  endtask

  function automatic logic [NUM_CH*IN_WIDTH-1:0] rnd_smp();
    logic [NUM_CH*IN_WIDTH-1:0] s;
    for (int c = 0; c < NUM_CH; c++) s[c*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom);
    return s;
  endfunction

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, rnd_smp(), rdy);
  endtask

  // Monitor: compare each accepted result and the count of earlier acceptances.
  int mon_cnt = 0;
  always @(negedge clk) begin
    if (i_reset) mon_cnt = 0;
    else if (o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", o_data, 0);
      else chk("data", o_data, exp_q.pop_front());
      chk("count", o_sample_count, mon_cnt);
      mon_cnt++;
    end
  end

  logic [NUM_CH*IN_WIDTH-1:0] s;
  logic [CNT_WIDTH-1:0] cnt_before;
  int r;

  initial begin
    // 1: reset, not initialised, SAMPLE status, strobes ignored
    i_iagc_status = SAMPLE;
    i_reset = 1'b1;
    cycle(1'b0, '0, 1'b0);
    i_reset = 1'b0;
    chk("reset_data", o_data, 0);
    chk("reset_count", o_sample_count, 0);
    for (int i = 0; i < 10; i++) cycle(1'b1, rnd_smp(), 1'b1);

    // 2: k=0, every strobe yields a result one cycle later
    i_init_done = 1'b1;
    i_dec_log2 = '0;
    idle(3, 1'b1);
    s = rnd_smp(); s[15:0] = 16'h1234;
    cycle(1'b1, s, 1'b1);
    chk("t2_first_ch0", o_data[13:0], 14'h048D);
    idle(1, 1'b1);
    s = rnd_smp(); s[15:0] = 16'hFFFC;
    cycle(1'b1, s, 1'b1);
    chk("t2_second_ch0", o_data[13:0], 14'h3FFF);
    idle(2, 1'b1);
    chk("t2_count", o_sample_count, 2);

    // 3: k=2, ch1 ramp pattern
    i_iagc_status = IDLE_ST; idle(2, 1'b1);
    i_dec_log2 = 3'd2; i_iagc_status = SAMPLE; idle(2, 1'b1);
    i_dec_log2 = 3'd5;
    for (int i = 0; i < 8; i++) begin
      s = rnd_smp(); s[31:16] = 16'((i % 4 + 1) * 256);
      cycle(1'b1, s, 1'b1);
      if (i == 3) begin
`ifdef ADC_CAPTURE_AVG_EN
        chk("t3_ch1", o_data[27:14], 14'h00A0);
`else
        chk("t3_ch1", o_data[27:14], 14'h0040);
`endif
      end
      if (i % 3 == 1) idle(1, 1'b1);
    end
    idle(2, 1'b1);

    // 4: k=0 with consumer stalled -> overrun, held result kept
    i_iagc_status = IDLE_ST; idle(2, 1'b1);
    i_dec_log2 = 3'd0; i_iagc_status = SAMPLE; idle(2, 1'b1);
    cnt_before = o_sample_count;
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_smp(), 1'b0);
    idle(2, 1'b0);
    chk("t4_count_stalled", o_sample_count - cnt_before, 0);
    idle(2, 1'b1);
    chk("t4_count_after", o_sample_count - cnt_before, 1);

    // 5: k=3, partial window abandoned, fresh window after re-entry
    i_iagc_status = IDLE_ST; idle(2, 1'b1);
    i_dec_log2 = 3'd3; i_iagc_status = SAMPLE; idle(2, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_smp(), 1'b1);
    i_iagc_status = IDLE_ST; idle(3, 1'b1);
    i_iagc_status = SAMPLE; idle(2, 1'b1);
    cnt_before = o_sample_count;
    for (int i = 0; i < 8; i++) cycle(1'b1, rnd_smp(), 1'b1);
    idle(2, 1'b1);
    chk("t5_results", o_sample_count - cnt_before, 1);

    // 6: largest exponent -> one result per 128 strobes
    i_iagc_status = IDLE_ST; idle(2, 1'b1);
    i_dec_log2 = KW'(15); i_iagc_status = SAMPLE; idle(2, 1'b1);
    cnt_before = o_sample_count;
    for (int i = 0; i < 256; i++) cycle(1'b1, rnd_smp(), 1'b1);
    idle(2, 1'b1);
    chk("t6_results", o_sample_count - cnt_before, 2);

    // Randomised traffic: status, exponent, init, reset and backpressure
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 4) i_reset = 1'b1;
      else if (r < 12 && i_init_done) i_init_done = 1'b0;
      else if (r < 150 && !i_init_done) i_init_done = 1'b1;
      if ($urandom_range(0, 99) < 4)
        i_iagc_status = (i_iagc_status == SAMPLE) ? ISZ'($urandom_range(0, 15)) : SAMPLE;
      if ($urandom_range(0, 99) < 10)
        i_dec_log2 = ($urandom_range(0, 9) < 8) ? KW'($urandom_range(0, 3)) : KW'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), rnd_smp(), ($urandom_range(0, 9) < 7));
      i_reset = 1'b0;
    end

    // Drain
    i_iagc_status = IDLE_ST;
    idle(5, 1'b1);
    chk("drain_queue", exp_q.size(), 0);
    chk("final_count", o_sample_count, m_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
Parametrised successor to the two-channel ADC front-end. It sits between the ADC controller's parallel sample outputs and the IAGC datapath. It takes NUM_CH signed samples of IN_WIDTH bits, gates them on the IAGC status code, decimates by 2^k, and reduces each sample to OUT_WIDTH MSBs. Results are presented on a valid/ready handshake with a sticky overrun flag.

Parameters:
NUM_CH, 2, number of ADC channels packed on the sample bus
IN_WIDTH, 16, controller sample width per channel (signed)
OUT_WIDTH, 14, output sample width per channel; must be <= IN_WIDTH
MAX_DEC_LOG2, 7, maximum decimation exponent
IAGC_STATUS_SIZE, 4, width of the IAGC status code
CNT_WIDTH, 32, width of the emitted-sample counter

Ports:
i_sys_clock  in  1  single system clock; all logic is on the rising edge
i_reset  in  1  synchronous, active-high reset
i_iagc_status  in  IAGC_STATUS_SIZE  IAGC FSM status code
i_init_done  in  1  controller initialisation complete (active high)
i_sample_valid  in  1  one-cycle strobe: i_samples holds a new conversion
i_samples  in  NUM_CH*IN_WIDTH  channel c occupies bits [c*IN_WIDTH +: IN_WIDTH]
i_dec_log2  in  $clog2(MAX_DEC_LOG2+1)  decimation exponent k
o_data  out  NUM_CH*OUT_WIDTH  reduced samples, same packing order as i_samples
o_valid  out  1  o_data is valid
i_ready  in  1  consumer accepts o_data when o_valid && i_ready
o_overrun  out  1  sticky flag: a result was dropped
o_sample_count  out  CNT_WIDTH  number of accepted results; wraps to 0
o_busy  out  1  high while in ST_CAPTURE

Behaviour:
- Reset values: o_data=0, o_valid=0, o_overrun=0, o_sample_count=0, o_busy=0. Reset enters ST_WAIT_INIT and clears the window counter.
- FSM states: ST_WAIT_INIT, ST_IDLE, ST_CAPTURE.
  - ST_WAIT_INIT -> ST_IDLE when i_init_done=1.
  - ST_IDLE -> ST_CAPTURE when i_iagc_status==4'b0011 (SAMPLE) and i_init_done=1.
  - ST_CAPTURE -> ST_IDLE when the status leaves SAMPLE.
  - Any state -> ST_WAIT_INIT when i_init_done falls.
- On entry to ST_CAPTURE:
  - i_dec_log2 is latched as k; values > MAX_DEC_LOG2 saturate to MAX_DEC_LOG2.
  - The window counter is zeroed and o_overrun is cleared.
  - Changes to i_dec_log2 while in ST_CAPTURE have no effect.
- Window:
  - Each i_sample_valid in ST_CAPTURE is one window sample.
  - A window closes on the 2^k-th strobe; the counter wraps to 0 on the same cycle.
  - Strobes outside ST_CAPTURE are ignored.
- Decimation without averaging: the first sample of the window is held; the other samples are discarded.
- Reduction per channel: out = held[IN_WIDTH-1 -: OUT_WIDTH] (MSB truncation, no rounding).
- Latency: o_valid rises and o_data updates on the clock edge after the closing strobe (1 cycle). For k=0, every strobe yields a result one cycle later.
- Handshake:
  - o_data and o_valid hold until o_valid && i_ready. On that edge, o_valid falls and o_sample_count increments.
  - Accepting a result and loading a new one on the same edge is allowed: o_valid stays 1, o_data takes the new value, and the count increments.
  - A new result arriving while o_valid=1 && i_ready=0 is dropped; o_overrun is set and stays set until reset or the next entry to ST_CAPTURE. The held output is unchanged.
- Leaving SAMPLE mid-window: the partial window is discarded with no output. A pending o_valid stays until accepted.
- Reset mid-transfer: o_valid is dropped immediately; the pending result is lost.
- o_sample_count wraps from 2^CNT_WIDTH-1 to 0 silently.

Optional Feature:
ADC_CAPTURE_AVG_EN
- Defined: each channel accumulates a signed sum of width IN_WIDTH+MAX_DEC_LOG2 over the window. At window close: avg = sum >>> k (arithmetic shift), then the same MSB truncation is applied to avg[IN_WIDTH-1:0]. The accumulator clears at window close and on entry to ST_CAPTURE.
- Undefined: first-sample decimation as above; no accumulator logic is built.

Decomposition:
- Shared package adc_capture_pkg holds:
  - IAGC status localparams (RESET 4'b0000 … SAMPLE 4'b0011 … HALT 4'b1100)
  - the FSM state typedef
  - a function computing the accumulator width
- One sub-module, adc_channel_reducer, instantiated NUM_CH times in a generate loop. It holds one channel's hold/accumulate register and its truncation logic.

Test Plan:
1. Reset, i_init_done=0, status=SAMPLE, 10 strobes -> o_valid never rises; o_busy=0.
2. init_done=1, status=SAMPLE, k=0, ready=1, ch0 samples 0x1234 and 0xFFFC -> o_data ch0 = 0x048D, then 0x3FFF, each 1 cycle after its strobe; o_sample_count=2.
3. k=2, ready=1, 8 strobes, ch1 = 0x0100, 0x0200, 0x0300, 0x0400 repeated -> 2 results, each with ch1=0x0040. With ADC_CAPTURE_AVG_EN, ch1=0x00A0.
4. k=0, i_ready=0, 3 strobes -> o_data holds the first result; o_overrun=1; count=0 until ready rises, then count=1.
5. k=3, status drops to IDLE after 5 strobes, then returns to SAMPLE with 8 strobes -> exactly one result, formed from the new window only; o_overrun cleared on re-entry.
6. i_dec_log2=15 with MAX_DEC_LOG2=7 -> one result per 128 strobes.
